// File: rtl/qdrii_regs_pkg.sv
// Shared definitions for the QDRII PicoBus register block: register offsets,
// the reset-pulse FSM state encoding and a helper for the DATA_i offsets.
package qdrii_regs_pkg;

    localparam int BUS_W = 128;

    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_ERR     = 8'h20;
    localparam logic [7:0] OFF_DATA0   = 8'h40;
    localparam logic [7:0] DATA_STRIDE = 8'h20;
    localparam logic [7:0] OFF_SIG     = 8'hE0;

    // Bit of the CTRL write word that holds the reset request.
    localparam int CTRL_RST_BIT = 64;

    // Width of one chip's status field in the CTRL read word.
    localparam int CTRL_FIELD_W = 16;

    typedef enum logic [1:0] {
        RST_IDLE = 2'd0,
        RST_HOLD = 2'd1,
        RST_REQ  = 2'd2
    } rst_state_e;

    // Byte offset of the read-data snapshot register for chip idx.
    function automatic logic [7:0] data_offset(input int idx);
        return OFF_DATA0 + DATA_STRIDE * 8'(idx);
    endfunction

endpackage

// File: rtl/qdrii_rst_pulse.sv
// Reset-pulse generator for the QDRII controllers. Guarantees a minimum
// pulse of RST_MIN_CYC cycles on every reset request rising edge, and then
// holds the reset for as long as the request stays set.
module qdrii_rst_pulse
    import qdrii_regs_pkg::*;
#(
    parameter int RST_MIN_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_req,
    output logic qdr_rst,
    output logic hold_entry
);

    localparam int CNT_W = (RST_MIN_CYC > 1) ? $clog2(RST_MIN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_MIN_CYC - 1);

    rst_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             req_d;
    logic             req_rise;

    assign req_rise = rst_req & ~req_d;

    // Combinational strobe so the owner of the status registers can clear
    // them on the very edge the FSM moves from IDLE into HOLD.
    assign hold_entry = (state == RST_IDLE) & req_rise;

    // Reset FSM with its minimum-width counter and registered reset output.
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RST_HOLD;
            cnt     <= CNT_LOAD;
            qdr_rst <= 1'b1;
            req_d   <= 1'b0;
        end else begin
            req_d <= rst_req;
            case (state)
                RST_IDLE: begin
                    if (req_rise) begin
                        state   <= RST_HOLD;
                        cnt     <= CNT_LOAD;
                        qdr_rst <= 1'b1;
                    end
                end
                RST_HOLD: begin
                    if (req_rise) begin
                        cnt <= CNT_LOAD;
                    end else if (cnt == '0) begin
                        if (rst_req) begin
                            state <= RST_REQ;
                        end else begin
                            state   <= RST_IDLE;
                            qdr_rst <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RST_REQ: begin
                    if (!rst_req) begin
                        state   <= RST_IDLE;
                        qdr_rst <= 1'b0;
                    end
                end
                default: begin
                    state   <= RST_IDLE;
                    qdr_rst <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/qdrii_picobus_regs.sv
// PicoBus responder for the QDRII test subsystem: reset control, calibration
// status, sticky traffic-generator error flags, per-chip read-data snapshots
// and a signature word, all in a 256-byte window at BASE_ADDR.
module qdrii_picobus_regs
    import qdrii_regs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1235_0000,
    parameter int          NUM_QDRII   = 3,
    parameter int          ERR_W       = 32,
    parameter int          RST_MIN_CYC = 16,
    parameter logic [31:0] SIG         = 32'h55AA_55AA
) (
    input  logic                         PicoClk,
    input  logic                         PicoRst_n,
    input  logic [31:0]                  PicoAddr,
    input  logic [BUS_W-1:0]             PicoDataIn,
    input  logic                         PicoWr,
    input  logic                         PicoRd,
    output logic [BUS_W-1:0]             PicoDataOut,
    output logic                         qdr_rst_o,
    input  logic [NUM_QDRII-1:0]         cal_done_i,
    input  logic [NUM_QDRII*ERR_W-1:0]   err_i,
    input  logic [NUM_QDRII*BUS_W-1:0]   rd_data_i,
    input  logic [NUM_QDRII-1:0]         rd_valid_i
);

    localparam int ERR_TOT = NUM_QDRII * ERR_W;

    logic                 hit;
    logic [7:0]           off;
    logic                 wr_ctrl;
    logic                 wr_err;
    logic                 rst_req;
    logic                 hold_entry;
    logic [ERR_TOT-1:0]   err_q;
    logic [ERR_TOT-1:0]   w1c;
    logic [BUS_W-1:0]     data_q [NUM_QDRII];
    logic [BUS_W-1:0]     ctrl_word;
    logic [BUS_W-1:0]     rd_mux;
    logic                 unused_wdata;

    assign hit     = (PicoAddr[31:8] == BASE_ADDR[31:8]);
    assign off     = PicoAddr[7:0];
    assign wr_ctrl = PicoWr & hit & (off == OFF_CTRL);
    assign wr_err  = PicoWr & hit & (off == OFF_ERR);
    assign w1c     = wr_err ? PicoDataIn[ERR_TOT-1:0] : '0;

    // Only a few write-data bits are architected; fold the rest away.
    assign unused_wdata = ^PicoDataIn;

    // Reset request bit, written through CTRL.
    always_ff @(posedge PicoClk) begin
        if (!PicoRst_n) begin
            rst_req <= 1'b0;
        end else if (wr_ctrl) begin
            rst_req <= PicoDataIn[CTRL_RST_BIT];
        end
    end

    qdrii_rst_pulse #(
        .RST_MIN_CYC (RST_MIN_CYC)
    ) u_rst_pulse (
        .clk        (PicoClk),
        .rst_n      (PicoRst_n),
        .rst_req    (rst_req),
        .qdr_rst    (qdr_rst_o),
        .hold_entry (hold_entry)
    );

    // Sticky error flags: frozen while the controllers are in reset, and a
    // new error on the same edge as a W1C keeps the flag set.
    always_ff @(posedge PicoClk) begin
        if (!PicoRst_n || hold_entry) begin
            err_q <= '0;
        end else if (!qdr_rst_o) begin
            err_q <= (err_q & ~w1c) | err_i;
        end
    end

    // Per-chip read-data snapshots.
    // NOTE: this array is software-visible state that must read 0 after
    // reset, so it is reset explicitly rather than left as an unreset memory.
    always_ff @(posedge PicoClk) begin
        for (int i = 0; i < NUM_QDRII; i++) begin
            if (!PicoRst_n || hold_entry) begin
                data_q[i] <= '0;
            end else if (rd_valid_i[i]) begin
                data_q[i] <= rd_data_i[i*BUS_W +: BUS_W];
            end
        end
    end

    // CTRL read word: {qdr_rst_o, cal_done} in the low bits of each chip field.
    // NOTE: the default assignment first keeps this combinational block from
    // inferring a latch on the bits no chip drives.
    always_comb begin
        ctrl_word = '0;
        for (int i = 0; i < NUM_QDRII; i++) begin
            ctrl_word[CTRL_FIELD_W*i +: 2] = {qdr_rst_o, cal_done_i[i]};
        end
    end

    // Register read mux; offsets without a register return 0.
    always_comb begin
        rd_mux = '0;
        if (off == OFF_CTRL) begin
            rd_mux = ctrl_word;
        end else if (off == OFF_ERR) begin
            rd_mux = BUS_W'(err_q);
        end else if (off == OFF_SIG) begin
            rd_mux = {96'b0, SIG};
        end else begin
            for (int i = 0; i < NUM_QDRII; i++) begin
                if (off == data_offset(i)) begin
                    rd_mux = data_q[i];
                end
            end
        end
    end

    // Registered read data, driven only in the cycle after an in-window read.
    always_ff @(posedge PicoClk) begin
        if (!PicoRst_n) begin
            PicoDataOut <= '0;
        end else if (PicoRd && hit) begin
            PicoDataOut <= rd_mux;
        end else begin
            PicoDataOut <= '0;
        end
    end

endmodule

// File: tb/tb_qdrii_picobus_regs.sv
// Self-checking bench for qdrii_picobus_regs: directed scenarios plus a
// randomized phase, all compared against a cycle-level reference model.
module tb_qdrii_picobus_regs;

    localparam logic [31:0] BASE    = 32'h1235_0000;
    localparam int          NUM     = 3;
    localparam int          ERR_W   = 32;
    localparam int          RST_MIN = 16;
    localparam logic [31:0] SIGV    = 32'h55AA_55AA;

    logic                   PicoClk = 1'b0;
    logic                   PicoRst_n;
    logic [31:0]            PicoAddr;
    logic [127:0]           PicoDataIn;
    logic                   PicoWr;
    logic                   PicoRd;
    logic [127:0]           PicoDataOut;
    logic                   qdr_rst_o;
    logic [NUM-1:0]         cal_done_i;
    logic [NUM*ERR_W-1:0]   err_i;
    logic [NUM*128-1:0]     rd_data_i;
    logic [NUM-1:0]         rd_valid_i;

    qdrii_picobus_regs #(
        .BASE_ADDR   (BASE),
        .NUM_QDRII   (NUM),
        .ERR_W       (ERR_W),
        .RST_MIN_CYC (RST_MIN),
        .SIG         (SIGV)
    ) dut (
        .PicoClk     (PicoClk),
        .PicoRst_n   (PicoRst_n),
        .PicoAddr    (PicoAddr),
        .PicoDataIn  (PicoDataIn),
        .PicoWr      (PicoWr),
        .PicoRd      (PicoRd),
        .PicoDataOut (PicoDataOut),
        .qdr_rst_o   (qdr_rst_o),
        .cal_done_i  (cal_done_i),
        .err_i       (err_i),
        .rd_data_i   (rd_data_i),
        .rd_valid_i  (rd_valid_i)
    );

    always #5 PicoClk = ~PicoClk;

    // Reference model: reset output as a deadline (edge index before which
    // the minimum pulse is still running) plus plain arrays for registers.
    int                   cyc = 0;
    int                   busy_until = 0;
    bit                   qdr_m = 1'b1;
    bit                   req_m = 1'b0;
    bit                   req_prev_m = 1'b0;
    logic [NUM*ERR_W-1:0] err_m = '0;
    logic [127:0]         data_m [NUM];
    logic [127:0]         out_m = '0;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] obs_out;
    int           run_len = 0;
    int           last_run = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [127:0] model_read(input logic [31:0] a);
        logic [127:0] v;
        int o;
        v = '0;
        o = int'(a[7:0]);
        if (a[31:8] != BASE[31:8]) return v;
        if (o == 'h00) begin
            for (int i = 0; i < NUM; i++) begin
                v[16*i+1] = qdr_m;
                v[16*i]   = cal_done_i[i];
            end
        end else if (o == 'h20) begin
            v[NUM*ERR_W-1:0] = err_m;
        end else if (o == 'hE0) begin
            v[31:0] = SIGV;
        end else begin
            for (int i = 0; i < NUM; i++)
                if (o == 'h40 + 'h20 * i) v = data_m[i];
        end
        return v;
    endfunction

    // One clock: evaluate the model on pre-edge inputs, step, compare.
    task automatic tick();
        logic [127:0]         nxt_out;
        logic [31:0]          p_addr;
        logic [127:0]         p_din;
        logic                 p_wr;
        logic                 p_rst_n;
        logic [NUM*ERR_W-1:0] p_err;
        logic [NUM-1:0]       p_valid;
        logic [NUM*128-1:0]   p_rdata;
        logic [NUM*ERR_W-1:0] w1c;
        bit                   rise;
        bit                   clear;
        bit                   nxt_qdr;

        nxt_out = PicoRd ? model_read(PicoAddr) : '0;
        p_addr  = PicoAddr;
        p_din   = PicoDataIn;
        p_wr    = PicoWr;
        p_rst_n = PicoRst_n;
        p_err   = err_i;
        p_valid = rd_valid_i;
        p_rdata = rd_data_i;

        @(posedge PicoClk);
        cyc++;
        if (!p_rst_n) begin
            qdr_m      = 1'b1;
            busy_until = cyc + RST_MIN;
            req_m      = 1'b0;
            req_prev_m = 1'b0;
            err_m      = '0;
            for (int i = 0; i < NUM; i++) data_m[i] = '0;
            out_m      = '0;
        end else begin
            rise  = req_m && !req_prev_m;
            clear = 1'b0;
            if (qdr_m && cyc <= busy_until) begin
                if (rise) busy_until = cyc + RST_MIN;
                nxt_qdr = (cyc < busy_until) || req_m;
            end else if (qdr_m) begin
                nxt_qdr = req_m;
            end else if (rise) begin
                busy_until = cyc + RST_MIN;
                nxt_qdr    = 1'b1;
                clear      = 1'b1;
            end else begin
                nxt_qdr = 1'b0;
            end
            w1c = (p_wr && p_addr == BASE + 32'h20) ? p_din[NUM*ERR_W-1:0] : '0;
            if (clear) err_m = '0;
            else if (!qdr_m) err_m = (err_m & ~w1c) | p_err;
            for (int i = 0; i < NUM; i++) begin
                if (clear) data_m[i] = '0;
                else if (p_valid[i]) data_m[i] = p_rdata[i*128 +: 128];
            end
            req_prev_m = req_m;
            if (p_wr && p_addr == BASE) req_m = p_din[64];
            qdr_m = nxt_qdr;
            out_m = nxt_out;
        end

        #1;
        check("qdr_rst_o", {127'b0, qdr_rst_o}, {127'b0, qdr_m});
        check("PicoDataOut", PicoDataOut, out_m);
        obs_out = PicoDataOut;
        if (qdr_rst_o) begin
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [127:0] d);
        PicoAddr   = a;
        PicoDataIn = d;
        PicoWr     = 1'b1;
        tick();
        PicoWr     = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [127:0] d);
        PicoAddr = a;
        PicoRd   = 1'b1;
        tick();
        d        = obs_out;
        PicoRd   = 1'b0;
        tick();
    endtask

    task automatic wait_rst_low(input string tag);
        for (int k = 0; k < 64 && qdr_rst_o; k++) tick();
        check(tag, {127'b0, qdr_rst_o}, 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] d;
        logic [127:0] pre;
        logic [127:0] one37;
        logic [127:0] pattern;
        logic [127:0] snap0;

        one37   = 128'd1 << 37;
        pattern = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        for (int i = 0; i < NUM; i++) data_m[i] = '0;

        PicoRst_n  = 1'b0;
        PicoAddr   = '0;
        PicoDataIn = '0;
        PicoWr     = 1'b0;
        PicoRd     = 1'b0;
        cal_done_i = '0;
        err_i      = '0;
        rd_data_i  = '0;
        rd_valid_i = '0;

        // Power-on reset and the minimum-width pulse after release.
        repeat (3) tick();
        check("reset_out", PicoDataOut, 128'd0);
        PicoRst_n = 1'b1;
        run_len   = 1;
        bus_read(BASE, d);
        check("hold_ctrl", d, 128'h0002_0002_0002);
        wait_rst_low("por_end");
        check("por_pulse_len", last_run, 16);

        // Software reset request, cleared early, still gives a full pulse.
        bus_write(BASE, {64'h1, 64'h0});
        tick();
        bus_write(BASE, '0);
        wait_rst_low("req_end");
        check("req_pulse_len", last_run, 16);
        cal_done_i = 3'b111;
        bus_read(BASE, d);
        check("ctrl_cal", d, 128'h0001_0001_0001);

        // Sticky error flag, set-wins against a coincident W1C, then clear.
        err_i[37] = 1'b1;
        tick();
        err_i = '0;
        bus_read(BASE + 32'h20, d);
        check("err_sticky", d, one37);
        PicoAddr   = BASE + 32'h20;
        PicoDataIn = one37;
        PicoWr     = 1'b1;
        err_i[37]  = 1'b1;
        tick();
        PicoWr = 1'b0;
        err_i  = '0;
        bus_read(BASE + 32'h20, d);
        check("err_set_wins", d, one37);
        bus_write(BASE + 32'h20, one37);
        bus_read(BASE + 32'h20, d);
        check("err_w1c", d, 128'd0);

        // Read-data snapshot of chip 2 and the one-cycle read window.
        rd_data_i[2*128 +: 128] = pattern;
        rd_valid_i = 3'b100;
        tick();
        rd_valid_i = '0;
        tick();
        pre = obs_out;
        check("data_pre", pre, 128'd0);
        bus_read(BASE + 32'h80, d);
        check("data2", d, pattern);
        check("data_post", obs_out, 128'd0);

        // Signature, hole offsets and out-of-window accesses.
        bus_read(BASE + 32'hE0, d);
        check("sig", d, {96'b0, SIGV});
        bus_write(BASE + 32'hC0, '1);
        bus_read(BASE + 32'hC0, d);
        check("hole_read", d, 128'd0);
        err_i[3] = 1'b1;
        tick();
        err_i = '0;
        bus_write(32'h1236_0000, {64'h1, 64'h0});
        bus_write(32'h1236_0020, '1);
        bus_read(32'h1236_0000, d);
        check("outside_read", d, 128'd0);
        repeat (3) tick();
        check("outside_no_rst", {127'b0, qdr_rst_o}, 128'd0);
        bus_read(BASE + 32'h20, d);
        check("outside_no_w1c", d, 128'd1 << 3);
        bus_write(BASE + 32'h20, '1);

        // Hold reset in REQ, load a snapshot, then hit the bus reset.
        bus_write(BASE, {64'h1, 64'h0});
        repeat (24) tick();
        check("req_held", {127'b0, qdr_rst_o}, 128'd1);
        err_i = '1;
        snap0 = {$urandom, $urandom, $urandom, $urandom};
        rd_data_i[127:0] = snap0;
        rd_valid_i = 3'b001;
        tick();
        err_i      = '0;
        rd_valid_i = '0;
        bus_read(BASE + 32'h40, d);
        check("data_in_req", d, snap0);
        bus_read(BASE + 32'h20, d);
        check("err_frozen", d, 128'd0);
        PicoRst_n = 1'b0;
        PicoAddr  = BASE + 32'h40;
        PicoRd    = 1'b1;
        tick();
        check("rst_out", obs_out, 128'd0);
        check("rst_qdr", {127'b0, qdr_rst_o}, 128'd1);
        PicoRd = 1'b0;
        tick();
        PicoRst_n = 1'b1;
        run_len   = 1;
        wait_rst_low("rerst_end");
        check("rerst_pulse_len", last_run, 16);
        bus_read(BASE + 32'h40, d);
        check("data_cleared", d, 128'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [7:0] offs [8];
            offs = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0};
            PicoRst_n = ($urandom_range(0, 199) != 0);
            PicoRd    = ($urandom_range(0, 9) < 4);
            PicoWr    = ($urandom_range(0, 9) < 3);
            PicoAddr  = BASE;
            PicoAddr[7:0] = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                                        : offs[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0)
                PicoAddr = PicoAddr ^ (32'd1 << $urandom_range(8, 31));
            PicoDataIn     = {$urandom, $urandom, $urandom, $urandom};
            PicoDataIn[64] = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NUM; i++) begin
                err_i[i*ERR_W +: ERR_W] = $urandom & $urandom & $urandom & $urandom;
                rd_data_i[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
            end
            rd_valid_i = NUM'($urandom) & NUM'($urandom);
            cal_done_i = NUM'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
